ad9265_adc_pack: RTL and testbench

AD9265_ADC_PACK -- requirements
Module: ad9265_adc_pack

---
 rtl/ad9265_adc_pack_pkg.sv | 12 +
 rtl/ad9265_pack_fifo.sv | 98 +++++++++
 rtl/ad9265_adc_pack.sv | 88 ++++++++
 tb/tb_ad9265_adc_pack.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ad9265_adc_pack_pkg.sv
// Shared constants for the AD9265 sample packer: four 16-bit samples per
// 64-bit DMA word, and the default FIFO depth exponent.
package ad9265_adc_pack_pkg;

    localparam int PACK_RATIO          = 4;
    localparam int SAMPLE_WIDTH        = 16;
    localparam int WORD_WIDTH          = 64;
    localparam int FIFO_ADDR_WIDTH_DEF = 3;

    typedef logic [1:0] pack_cnt_t;

endpackage

// File: rtl/ad9265_pack_fifo.sv
// First-word-fall-through FIFO for packed words. The head word is held in an
// output register that is loaded with the word that will be oldest after the
// current edge, so dma_data is a flop output. Storage is not reset.
module ad9265_pack_fifo #(
    parameter int AW = 3,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_r [0:DEPTH-1];
    logic [AW:0]   wr_r;
    logic [AW:0]   rd_r;
    logic [AW:0]   level_r;
    logic [DW-1:0] dout_r;

    logic          full_s;
    logic          empty_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [AW:0]   rd_next_s;
    logic [AW:0]   level_next_s;
    logic [DW-1:0] dout_next_s;

    assign full_s    = (level_r == FULL_LVL);
    assign empty_s   = (level_r == '0);
    assign pop_ok_s  = pop & ~empty_s;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Next read pointer, next level and the word that will be at the head.
    always_comb begin
        rd_next_s    = rd_r;
        level_next_s = level_r;
        dout_next_s  = dout_r;
        if (pop_ok_s) begin
            rd_next_s = rd_r + (AW+1)'(1);
        end else begin
            rd_next_s = rd_r;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_next_s = level_r + (AW+1)'(1);
            2'b01:   level_next_s = level_r - (AW+1)'(1);
            default: level_next_s = level_r;
        endcase
        if (level_next_s == '0) begin
            dout_next_s = dout_r;
        end else if (push_ok_s && (wr_r == rd_next_s)) begin
            // The word being written now becomes the head (bypass).
            dout_next_s = din;
        end else begin
            dout_next_s = mem_r[rd_next_s[AW-1:0]];
        end
    end

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_r[AW-1:0]] <= din;
        end
    end

    // Pointers, level and registered head word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_r    <= '0;
            rd_r    <= '0;
            level_r <= '0;
            dout_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_r <= wr_r + (AW+1)'(1);
            end
            rd_r    <= rd_next_s;
            level_r <= level_next_s;
            dout_r  <= dout_next_s;
        end
    end

    assign dout  = dout_r;
    assign valid = ~empty_s;
    assign full  = full_s;
    assign empty = empty_s;
    assign level = level_r;

endmodule

// File: rtl/ad9265_adc_pack.sv
// Packs four consecutive enabled samples into one 64-bit word (sample 0 in
// the low bits) and queues it for DMA. A word completed while the FIFO is
// full and not draining is dropped and flagged on adc_dovf for one cycle.
module ad9265_adc_pack
    import ad9265_adc_pack_pkg::*;
#(
    parameter int FIFO_ADDR_WIDTH = FIFO_ADDR_WIDTH_DEF
) (
    input  logic                       adc_clk,
    input  logic                       adc_rstn,
    input  logic                       adc_enable,
    input  logic                       adc_valid,
    input  logic [15:0]                adc_data,
    output logic                       adc_dovf,
    output logic                       dma_valid,
    input  logic                       dma_ready,
    output logic [63:0]                dma_data,
    output logic [FIFO_ADDR_WIDTH:0]   fifo_level
);

    localparam int PART_WIDTH = WORD_WIDTH - SAMPLE_WIDTH;

    pack_cnt_t               cnt_r;
    logic [PART_WIDTH-1:0]   pack_r;
    logic                    dovf_r;

    logic                    sample_s;
    logic                    push_s;
    logic                    pop_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    ovf_s;
    logic [WORD_WIDTH-1:0]   word_s;

    assign sample_s = adc_valid & adc_enable;
    assign push_s   = sample_s & (cnt_r == 2'd3);
    // The fourth sample goes straight into the word, so no dead cycle.
    assign word_s   = {adc_data, pack_r};
    assign pop_s    = dma_valid & dma_ready;
    assign ovf_s    = push_s & full_s & ~pop_s;

    // Pack counter and partial-group register; disable discards the group.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            cnt_r  <= 2'd0;
            pack_r <= '0;
        end else if (!adc_enable) begin
            cnt_r  <= 2'd0;
            pack_r <= '0;
        end else if (adc_valid) begin
            case (cnt_r)
                2'd0:    pack_r[15:0]  <= adc_data;
                2'd1:    pack_r[31:16] <= adc_data;
                2'd2:    pack_r[47:32] <= adc_data;
                default: pack_r        <= pack_r;
            endcase
            cnt_r <= cnt_r + 2'd1;
        end
    end

    // One-cycle overflow pulse per dropped word.
    always_ff @(posedge adc_clk or negedge adc_rstn) begin
        if (!adc_rstn) begin
            dovf_r <= 1'b0;
        end else begin
            dovf_r <= ovf_s;
        end
    end

    assign adc_dovf = dovf_r;

    ad9265_pack_fifo #(
        .AW (FIFO_ADDR_WIDTH),
        .DW (WORD_WIDTH)
    ) u_fifo (
        .clk   (adc_clk),
        .rstn  (adc_rstn),
        .push  (push_s),
        .din   (word_s),
        .pop   (pop_s),
        .dout  (dma_data),
        .valid (dma_valid),
        .full  (full_s),
        .empty (empty_s),
        .level (fifo_level)
    );

endmodule

// File: tb/tb_ad9265_adc_pack.sv
// Scoreboard bench for ad9265_adc_pack: a reference model pushes expected
// words on each clock edge, a monitor pops and compares on every DMA
// handshake, and directed scenarios check hand-computed words.
module tb_ad9265_adc_pack;

    logic        adc_clk = 1'b0;
    logic        adc_rstn = 1'b0;
    logic        adc_enable = 1'b0;
    logic        adc_valid = 1'b0;
    logic [15:0] adc_data = 16'h0;
    logic        dma_ready = 1'b0;
    logic        adc_dovf;
    logic        dma_valid;
    logic [63:0] dma_data;
    logic [3:0]  fifo_level;

    int checks = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic [63:0] pop_log[$];
    int          ml = 0;
    int          mcnt = 0;
    logic [63:0] mpack = 64'h0;
    int          mdrops = 0;
    logic        exp_dovf = 1'b0;
    int          dovf_cnt = 0;

    ad9265_adc_pack #(.FIFO_ADDR_WIDTH(3)) dut (
        .adc_clk    (adc_clk),
        .adc_rstn   (adc_rstn),
        .adc_enable (adc_enable),
        .adc_valid  (adc_valid),
        .adc_data   (adc_data),
        .adc_dovf   (adc_dovf),
        .dma_valid  (dma_valid),
        .dma_ready  (dma_ready),
        .dma_data   (dma_data),
        .fifo_level (fifo_level)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: evaluates each edge from the inputs applied before it.
    always @(posedge adc_clk) begin
        logic pop_m, push_m, drop_m;
        if (adc_rstn) begin
            pop_m  = (ml > 0) && dma_ready;
            push_m = 1'b0;
            drop_m = 1'b0;
            if (!adc_enable) begin
                mcnt = 0;
            end else if (adc_valid) begin
                mpack[mcnt*16 +: 16] = adc_data;
                if (mcnt == 3) push_m = 1'b1;
                mcnt = (mcnt + 1) % 4;
            end
            if (push_m) begin
                if (ml == 8 && !pop_m) begin
                    drop_m = 1'b1;
                    mdrops++;
                end else begin
                    exp_q.push_back(mpack);
                end
            end
            ml = ml + ((push_m && !drop_m) ? 1 : 0) - (pop_m ? 1 : 0);
            exp_dovf = drop_m;
        end
    end

    // Asynchronous reset discards everything in the model too.
    always @(negedge adc_rstn) begin
        exp_q.delete();
        ml = 0;
        mcnt = 0;
        exp_dovf = 1'b0;
    end

    // Monitor: compares status every cycle and pops on each handshake.
    always @(negedge adc_clk) begin
        logic [63:0] w;
        chk("level", 64'(fifo_level), 64'(ml));
        chk("valid", 64'(dma_valid), 64'(ml > 0));
        chk("dovf", 64'(adc_dovf), 64'(exp_dovf));
        if (adc_dovf) dovf_cnt++;
        if (dma_valid && dma_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got %h expected none", dma_data);
            end else begin
                w = exp_q.pop_front();
                chk("data", dma_data, w);
            end
            pop_log.push_back(dma_data);
        end
    end

    // One clock: inputs held across the next rising edge.
    task automatic cyc(input logic v, input logic e, input logic [15:0] d, input logic r);
        adc_valid  = v;
        adc_enable = e;
        adc_data   = d;
        dma_ready  = r;
        @(posedge adc_clk);
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 16'h0, r);
    endtask

    initial begin
        int base;
        int dv0;

        // Reset state
        #12;
        chk("rst_valid", 64'(dma_valid), 64'h0);
        chk("rst_data", dma_data, 64'h0);
        chk("rst_level", 64'(fifo_level), 64'h0);
        chk("rst_dovf", 64'(adc_dovf), 64'h0);
        @(posedge adc_clk);
        #1;
        adc_rstn = 1'b1;
        idle(2, 1'b1);

        // Single group straight through
        base = pop_log.size();
        for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b1, 16'(i), 1'b1);
        idle(3, 1'b1);
        chk("basic_count", 64'(pop_log.size() - base), 64'd1);
        if (pop_log.size() > base) chk("basic_word", pop_log[base], 64'h0004_0003_0002_0001);
        chk("basic_level", 64'(fifo_level), 64'h0);

        // Fill, overflow one word, then drain
        base = pop_log.size();
        dv0 = dovf_cnt;
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0);
        chk("full_level", 64'(fifo_level), 64'd8);
        for (int i = 32; i < 36; i++) cyc(1'b1, 1'b1, 16'(i), 1'b0);
        idle(2, 1'b0);
        chk("ovf_pulses", 64'(dovf_cnt - dv0), 64'd1);
        chk("ovf_level", 64'(fifo_level), 64'd8);
        idle(12, 1'b1);
        chk("ovf_drained", 64'(pop_log.size() - base), 64'd8);
        if (pop_log.size() > base) chk("ovf_first", pop_log[base], 64'h0003_0002_0001_0000);

        // Full FIFO with DMA draining: push+pop edges never overflow
        for (int i = 0; i < 32; i++) cyc(1'b1, 1'b1, 16'(16'h100 + i), 1'b0);
        dv0 = dovf_cnt;
        for (int i = 0; i < 40; i++) cyc(1'b1, 1'b1, 16'(16'h200 + i), 1'b1);
        idle(12, 1'b1);
        chk("fullpop_no_dovf", 64'(dovf_cnt - dv0), 64'd0);

        // Disable discards the partial group
        base = pop_log.size();
        cyc(1'b1, 1'b1, 16'h5555, 1'b1);
        cyc(1'b1, 1'b1, 16'h6666, 1'b1);
        cyc(1'b1, 1'b0, 16'h7777, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 16'(16'hA000 + i), 1'b1);
        idle(3, 1'b1);
        chk("disable_count", 64'(pop_log.size() - base), 64'd1);
        if (pop_log.size() > base) chk("disable_word", pop_log[base], 64'hA003_A002_A001_A000);

        // Reset with 5 words queued and 2 samples pending
        for (int i = 0; i < 22; i++) cyc(1'b1, 1'b1, 16'(16'h300 + i), 1'b0);
        chk("pre_rst_level", 64'(fifo_level), 64'd5);
        adc_rstn = 1'b0;
        #2;
        chk("async_valid", 64'(dma_valid), 64'h0);
        chk("async_data", dma_data, 64'h0);
        chk("async_level", 64'(fifo_level), 64'h0);
        @(posedge adc_clk);
        #1;
        adc_rstn = 1'b1;
        base = pop_log.size();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 16'(16'hB000 + i), 1'b1);
        idle(4, 1'b1);
        chk("post_rst_count", 64'(pop_log.size() - base), 64'd1);
        if (pop_log.size() > base) chk("post_rst_word", pop_log[base], 64'hB003_B002_B001_B000);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            cyc(1'($urandom), ($urandom_range(0, 31) != 0), 16'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        idle(12, 1'b1);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
        chk("dovf_vs_drops", 64'(dovf_cnt), 64'(mdrops));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
